seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle signed 32-bit integer divider for the processor's execute stage.
- Sits beside the combinational ALU ops (add/sub, bitwise and/or) and takes the operations that cannot complete in one cycle.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Start is a single-cycle request; completion is a single-cycle ready pulse. The pipeline stalls on busy.

Parameters:
N, 32, operand/result width in bits (must be >= 2)

Ports:
clock  input  1  rising-edge clock
ctrl_reset_n  input  1  reset, asynchronous, active-low; async assert, synchronous deassert supplied externally
ctrl_DIV  input  1  start pulse; operands sampled on the same edge
data_operandA  input  N  dividend, two's complement
data_operandB  input  N  divisor, two's complement
data_result  output  N  quotient, two's complement, truncated toward zero
data_remainder  output  N  remainder; sign follows dividend
data_exception  output  1  divide-by-zero or overflow flag; valid when data_resultRDY=1
data_resultRDY  output  1  one-cycle completion pulse
busy  output  1  high while an operation is in flight

Behaviour:
- Reset (ctrl_reset_n=0, any time, including mid-operation):
  - State goes to IDLE and the operation is aborted.
  - data_result, data_remainder, data_exception, data_resultRDY and busy all become 0 immediately.
- States and transitions:
  - IDLE: ctrl_DIV=1 goes to CALC.
  - CALC: runs N iterations, then goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE, or to CALC if ctrl_DIV=1.
- Start (edge where ctrl_DIV=1 in IDLE or DONE):
  - Latch |A| and |B|, sign_q = A[N-1]^B[N-1], and sign_r = A[N-1].
  - Clear the iteration counter and the partial remainder.
  - busy=1 from the next cycle.
- CALC iteration (one per edge):
  - Shift {rem, dvd} left by 1.
  - trial = rem - |B|, computed N+1 bits wide.
  - If trial is non-negative: rem = trial and the shifted-in quotient bit = 1; otherwise the bit is 0.
  - The counter increments from 0 to N-1. Leave CALC after the edge where counter = N-1.
- Latency:
  - Start on edge 0; iterations on edges 1..N.
  - Edge N+1 registers the final outputs and enters DONE.
  - data_resultRDY=1 for exactly the DONE cycle; busy=0 in DONE.
- Sign fix-up, applied at entry to DONE:
  - quotient = sign_q ? -q : q
  - remainder = sign_r ? -r : r
- Divide by zero (B=0):
  - Detected at start; CALC is skipped and DONE is entered on edge 1.
  - data_result=0, data_remainder=0, data_exception=1, data_resultRDY=1.
- Overflow (A = -2^(N-1), B = -1):
  - Runs the full latency.
  - data_result = 2^(N-1) (0x80000000), data_remainder=0, data_exception=1.
- Exception clearing: data_exception=0 for every other result.
- Output hold: data_result, data_remainder and data_exception hold their values until the next start or reset.
- ctrl_DIV while busy=1 is ignored: no queueing, operands are not resampled.
- ctrl_DIV in the DONE cycle:
  - The current data_resultRDY pulse still occurs.
  - A new operation starts and the outputs hold until its completion.
- Operand changes after the start edge have no effect (operands are latched at start).
- |-2^(N-1)| is computed in the N+1-bit datapath so it does not wrap.

Decomposition:
- Shared package (divider_pkg):
  - State encoding constants: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Default width N=32.
  - Counter width constant, clog2(N).
- One natural sub-module: div_step.
  - Combinational single iteration.
  - Inputs: rem[N:0], dvd MSB, |B|.
  - Outputs: next rem, quotient bit.
  - Instantiated once inside seq_divider.
- Use a generate loop for the N-bit conditional negation, in the same structural style as the bitwise op blocks.

Test Plan:
- Reset mid-operation: start 100/7, assert ctrl_reset_n=0 on cycle 5 -> all outputs 0 immediately, busy=0; after release, a new start 9/3 gives data_result=3, data_remainder=0.
- Basic unsigned: A=100, B=7, ctrl_DIV pulse -> data_resultRDY high exactly on cycle 33 after start; data_result=14, data_remainder=2, data_exception=0; busy=1 cycles 1..32.
- Signs: -100/7 -> result -14 (0xFFFFFFF2), remainder -2; 100/-7 -> result -14, remainder 2; -100/-7 -> result 14, remainder -2.
- Divide by zero: A=5, B=0 -> data_resultRDY on cycle 1, data_exception=1, data_result=0, data_remainder=0.
- Overflow: A=0x80000000, B=0xFFFFFFFF -> cycle 33: data_result=0x80000000, data_remainder=0, data_exception=1.
- Back-to-back and ignore:
  - ctrl_DIV pulses at cycle 10 with A=1, B=1 are ignored.
  - ctrl_DIV in the DONE cycle with 50/5 -> first result (100/7=14) reported, second ready 33 cycles later with data_result=10.
  - Outputs are stable between the two ready pulses.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width, counter and state definitions for the sequential divider
package divider_pkg;

    localparam int DIV_N = 32;
    localparam int CNT_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration producing one quotient bit
module div_step
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0] rem_i,
    input  logic       dvd_msb_i,
    input  logic [N:0] divisor_i,
    output logic [N:0] rem_o,
    output logic       q_bit_o
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    assign shifted = {rem_i, dvd_msb_i};
    // One extra bit of headroom so the borrow is the sign of the trial subtraction
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~trial[N+1];
    assign rem_o   = q_bit_o ? trial[N:0] : shifted[N:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed divider, one quotient bit per clock
module seq_divider
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clock,
    input  logic         ctrl_reset_n,
    input  logic         ctrl_DIV,
    input  logic [N-1:0] data_operandA,
    input  logic [N-1:0] data_operandB,
    output logic [N-1:0] data_result,
    output logic [N-1:0] data_remainder,
    output logic         data_exception,
    output logic         data_resultRDY,
    output logic         busy
);

    localparam int CW = $clog2(N);

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]   rem_q, rem_d;
    logic [N-1:0] dvd_q, dvd_d;
    logic [N:0]   div_q, div_d;
    logic         qneg_q, qneg_d, rneg_q, rneg_d;
    logic         dz_q, dz_d, ovf_q, ovf_d, last_q, last_d;
    logic [N-1:0] res_q, res_d, rout_q, rout_d;
    logic         exc_q, exc_d;

    logic         start;
    logic [N-1:0] abs_a;
    logic [N:0]   abs_b;
    logic [N:0]   step_rem;
    logic         step_bit;
    logic [N-1:0] q_x, r_x, q_fix, r_fix;

    // The most negative dividend maps to 2^(N-1), which is exact as an unsigned N-bit value
    assign abs_a = data_operandA[N-1] ? ({N{1'b0}} - data_operandA) : data_operandA;
    assign abs_b = data_operandB[N-1] ? ({(N+1){1'b0}} - {1'b1, data_operandB})
                                      : {1'b0, data_operandB};
    assign start = ctrl_DIV && (state_q != CALC);

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[N-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    for (genvar g = 0; g < N; g++) begin : g_neg
        assign q_x[g] = dvd_q[g] ^ qneg_q;
        assign r_x[g] = rem_q[g] ^ rneg_q;
    end
    assign q_fix = q_x + {{(N-1){1'b0}}, qneg_q};
    assign r_fix = r_x + {{(N-1){1'b0}}, rneg_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        res_d   = res_q;
        rout_d  = rout_q;
        exc_d   = exc_q;
        if (start) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = abs_a;
            div_d   = abs_b;
            qneg_d  = data_operandA[N-1] ^ data_operandB[N-1];
            rneg_d  = data_operandA[N-1];
            dz_d    = (data_operandB == '0);
            ovf_d   = (data_operandA == {1'b1, {(N-1){1'b0}}}) && (data_operandB == '1);
            // A zero divisor skips the iterations and goes straight to the fix-up edge
            last_d  = (data_operandB == '0);
        end else if (state_q == CALC) begin
            if (last_q) begin
                state_d = DONE;
                res_d   = dz_q ? '0 : q_fix;
                rout_d  = dz_q ? '0 : r_fix;
                exc_d   = dz_q | ovf_q;
            end else begin
                rem_d = step_rem;
                dvd_d = {dvd_q[N-2:0], step_bit};
                if (cnt_q == CW'(N-1)) begin
                    last_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
            res_q   <= '0;
            rout_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            res_q   <= res_d;
            rout_q  <= rout_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_remainder = rout_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == CALC);

endmodule
